instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 143 ++++++++++++++
 tb/tb_instr_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Encodes instruction descriptors into 32-bit words, buffers
//               them in a small FIFO and streams them to instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_class,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_fn,
  input  logic        in_s,
  input  logic        in_imm_sel,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rm,
  input  logic [23:0] in_imm,
  input  logic        in_last,
  input  logic        clear,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);

  localparam int              c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_fifo [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic [31:0]       r_addr;
  logic [15:0]       r_word_count;
  logic              r_err;
  logic [31:0]       w_word;
  logic [11:0]       w_op2;
  logic              w_accept;
  logic              w_legal;
  logic              w_push;
  logic              w_pop;
  logic              w_restart;

  // Ready depends only on registered state so memory back-pressure never loops back.
  assign in_ready   = (r_count < c_DEPTH) && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_accept   = in_valid & in_ready;
  assign w_legal    = (in_class != 2'b11);
  assign w_push     = w_accept & w_legal;
  assign mem_we     = (r_count != '0);
  assign w_pop      = mem_we & mem_ready;
  assign mem_wdata  = mem_we ? r_fifo[r_rd_ptr] : 32'h0;
  assign mem_addr   = r_addr;
  assign word_count = r_word_count;
  assign err        = r_err;
  assign done       = (r_state == S_DONE);
  assign w_restart  = (r_state == S_DONE) & clear;

  always_comb begin
    w_op2  = in_imm_sel ? in_imm[11:0] : {8'h00, in_rm};
    w_word = 32'h0;
    case (in_class)
      2'b00:   w_word = {in_cond, 2'b00, in_imm_sel, in_fn, in_s, in_rn, in_rd, w_op2};
      2'b01:   w_word = {in_cond, 2'b01, in_imm_sel, 2'b11, 2'b00, in_fn[0], in_rn, in_rd, w_op2};
      2'b10:   w_word = {in_cond, 4'b1010, in_imm};
      default: w_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_restart) begin
      r_addr       <= BASE_ADDR;
      r_word_count <= 16'h0000;
      r_err        <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr <= r_addr + 32'd4;
        if (r_word_count != 16'hFFFF) r_word_count <= r_word_count + 16'd1;
      end
      if (w_accept && !w_legal) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = in_last ? S_DRAIN : S_LOAD;
      S_LOAD:  if (w_accept && in_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_count == '0) w_state_nxt = S_DONE;
      S_DONE:  if (clear) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_s, in_imm_sel, in_last, clear, mem_ready;
  logic [1:0]  in_class;
  logic [3:0]  in_cond, in_fn, in_rn, in_rd, in_rm;
  logic [23:0] in_imm;
  logic        in_ready, mem_we, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] word_count;
  logic        w_in_ready, w_mem_we, w_done, w_err;
  logic [31:0] w_mem_addr, w_mem_wdata;
  logic [15:0] w_word_count;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  chk_en   = 0;
  bit  rand_mode = 0;
  bit  acc;

  logic [31:0] m_q[$];
  int unsigned m_n;
  bit          m_err;
  int          m_phase;   // 0 accepting, 1 draining, 2 done

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_cond(in_cond), .in_fn(in_fn), .in_s(in_s),
    .in_imm_sel(in_imm_sel), .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm),
    .in_imm(in_imm), .in_last(in_last), .clear(clear), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done),
    .err(err), .word_count(word_count)
  );

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(WRAP_BASE)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_class(in_class), .in_cond(in_cond), .in_fn(in_fn), .in_s(in_s),
    .in_imm_sel(in_imm_sel), .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm),
    .in_imm(in_imm), .in_last(in_last), .clear(clear), .mem_ready(mem_ready),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .done(w_done),
    .err(w_err), .word_count(w_word_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_encode(input logic [1:0] cls, input logic [3:0] cond,
      input logic [3:0] fn, input logic s, input logic isel, input logic [3:0] rn,
      input logic [3:0] rd, input logic [3:0] rm, input logic [23:0] imm);
    logic [31:0] op2, low, w;
    op2 = isel ? (32'(imm) % 32'd4096) : 32'(rm);
    low = 32'(rn) * 32'h1_0000 + 32'(rd) * 32'h1000 + op2;
    case (cls)
      2'd0:    w = 32'(cond) * 32'h1000_0000 + 32'(isel) * 32'h0200_0000
                 + 32'(fn) * 32'h0020_0000 + 32'(s) * 32'h0010_0000 + low;
      2'd1:    w = 32'(cond) * 32'h1000_0000 + 32'h0400_0000 + 32'(isel) * 32'h0200_0000
                 + 32'h0180_0000 + (32'(fn) % 32'd2) * 32'h0010_0000 + low;
      2'd2:    w = 32'(cond) * 32'h1000_0000 + 32'h0A00_0000 + 32'(imm);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Check current outputs, predict the effect of the coming edge, then advance one cycle.
  task automatic tick(output bit accepted);
    bit ready_m, pop_m;
    ready_m = (m_q.size() < DEPTH) && (m_phase == 0);
    if (rand_mode) begin
      mem_ready = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 9) == 0);
    end
    if (chk_en) begin
      check_eq("mem_we", 32'(mem_we), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check_eq("mem_wdata", mem_wdata, m_q[0]);
      check_eq("mem_addr", mem_addr, BASE + 32'(m_n * 4));
      check_eq("wrap_addr", w_mem_addr, WRAP_BASE + 32'(m_n * 4));
      check_eq("in_ready", 32'(in_ready), 32'(ready_m));
      check_eq("done", 32'(done), 32'(m_phase == 2));
      check_eq("err", 32'(err), 32'(m_err));
      check_eq("word_count", 32'(word_count), (m_n > 65535) ? 32'd65535 : 32'(m_n));
    end
    accepted = 0;
    if (reset) begin
      m_q.delete(); m_n = 0; m_err = 0; m_phase = 0;
    end else begin
      accepted = in_valid && ready_m;
      pop_m    = (m_q.size() != 0) && mem_ready;
      if (m_phase == 1 && m_q.size() == 0) m_phase = 2;
      else if (m_phase == 2 && clear) begin
        m_phase = 0; m_n = 0; m_err = 0;
      end
      if (pop_m) begin
        void'(m_q.pop_front());
        m_n++;
      end
      if (accepted) begin
        if (in_class == 2'd3) m_err = 1;
        else m_q.push_back(ref_encode(in_class, in_cond, in_fn, in_s, in_imm_sel,
                                      in_rn, in_rd, in_rm, in_imm));
        if (in_last) m_phase = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] fn,
      input logic s, input logic isel, input logic [3:0] rn, input logic [3:0] rd,
      input logic [3:0] rm, input logic [23:0] imm, input logic last);
    bit a;
    int guard;
    in_class = cls; in_cond = cond; in_fn = fn; in_s = s; in_imm_sel = isel;
    in_rn = rn; in_rd = rd; in_rm = rm; in_imm = imm; in_last = last; in_valid = 1'b1;
    a = 0;
    guard = 0;
    while (!a && guard < 200) begin
      tick(a);
      guard++;
    end
    if (!a) check_eq("accept_timeout", 32'(a), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_rand(input logic last);
    logic [1:0] cls;
    cls = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    send(cls, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
         4'($urandom), 4'($urandom), 24'($urandom), last);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      tick(acc);
      guard++;
    end
    check_eq("done_reached", 32'(done), 32'd1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(acc);
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_class = '0; in_cond = '0; in_fn = '0; in_s = 1'b0;
    in_imm_sel = 1'b0; in_rn = '0; in_rd = '0; in_rm = '0; in_imm = '0; in_last = 1'b0;
    clear = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    tick(acc);
    reset  = 1'b0;
    chk_en = 1;
    check_eq("rst_wdata", mem_wdata, 32'h0);
    check_eq("rst_we", 32'(mem_we), 32'd0);

    // Single DP word, one-cycle write latency
    mem_ready = 1'b1;
    send(2'd0, 4'hE, 4'b0100, 1'b0, 1'b0, 4'd2, 4'd1, 4'd3, 24'h0, 1'b1);
    check_eq("s1_we", 32'(mem_we), 32'd1);
    check_eq("s1_addr", mem_addr, 32'h0);
    check_eq("s1_wdata", mem_wdata, 32'hE082_1003);
    tick(acc);
    tick(acc);
    check_eq("s1_done", 32'(done), 32'd1);
    pulse_clear();

    // Load followed by branch
    send(2'd1, 4'hE, 4'b0001, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 24'h000004, 1'b0);
    check_eq("s2_ld", mem_wdata, 32'hE791_0004);
    send(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h000010, 1'b1);
    check_eq("s2_br", mem_wdata, 32'hEA00_0010);
    check_eq("s2_br_addr", mem_addr, 32'h4);
    wait_done();
    check_eq("s2_count", 32'(word_count), 32'd2);
    pulse_clear();

    // Fill the FIFO under back-pressure
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(2'd0, 4'hE, 4'h4, 1'b0, 1'b0, 4'd2, 4'(i), 4'd3, 24'h0, 1'b0);
    check_eq("s3_full_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("s3_hold", mem_wdata, 32'hE082_0003);
      tick(acc);
    end
    mem_ready = 1'b1;
    send(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h0000AA, 1'b1);
    wait_done();
    check_eq("s3_count", 32'(word_count), 32'd5);
    pulse_clear();

    // Illegal descriptor ending a program
    send(2'd3, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h0, 1'b1);
    tick(acc);
    check_eq("s4_err", 32'(err), 32'd1);
    check_eq("s4_done", 32'(done), 32'd1);
    pulse_clear();
    check_eq("s4_err_clr", 32'(err), 32'd0);
    check_eq("s4_addr_clr", mem_addr, BASE);
    check_eq("s4_wc_clr", 32'(word_count), 32'd0);

    // Reset with buffered words
    mem_ready = 1'b0;
    send(2'd0, 4'h1, 4'h2, 1'b1, 1'b1, 4'd3, 4'd4, 4'd5, 24'h000ABC, 1'b0);
    send(2'd1, 4'h2, 4'h0, 1'b0, 1'b0, 4'd6, 4'd7, 4'd8, 24'h0, 1'b0);
    reset = 1'b1;
    tick(acc);
    reset = 1'b0;
    check_eq("s5_we", 32'(mem_we), 32'd0);
    check_eq("s5_addr", mem_addr, BASE);
    check_eq("s5_ready", 32'(in_ready), 32'd1);
    mem_ready = 1'b1;
    repeat (3) tick(acc);

    // Randomized programs with random back-pressure and stray clears
    for (int p = 0; p < 8; p++) begin
      int n;
      n = $urandom_range(1, 10);
      rand_mode = 1;
      for (int i = 0; i < n; i++) send_rand(i == n - 1);
      wait_done();
      rand_mode = 0;
      clear = 1'b0;
      if (done) pulse_clear();
      tick(acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
